// File: rtl/timer_compare.sv
// Millisecond compare timer: counts time_in changes down from INTERVAL,
// raising a level interrupt on expiry; one-shot or periodic reload.
module timer_compare (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] time_in,
    input  logic [1:0]  bus_addr,
    input  logic        bus_we,
    input  logic        bus_re,
    input  logic [15:0] bus_wdata,
    output logic [15:0] bus_rdata,
    output logic        irq
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state, state_nx;
    logic [15:0] remain, remain_nx;
    logic [15:0] interval;
    logic        periodic, irq_en, pending;
    logic [15:0] prev;
    logic        primed;
    logic        tick, set_pend;
    logic        wr_interval, wr_ctrl, wr_status;
    logic        cmd_start, cmd_stop;

    assign tick        = primed && (time_in != prev);
    assign wr_interval = bus_we && (bus_addr == 2'd0);
    assign wr_ctrl     = bus_we && (bus_addr == 2'd1);
    assign wr_status   = bus_we && (bus_addr == 2'd2);
    assign cmd_start   = wr_ctrl && bus_wdata[0];
    assign cmd_stop    = wr_ctrl && bus_wdata[3];
    assign irq         = pending && irq_en;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev   <= '0;
            primed <= 1'b0;
        end else begin
            prev   <= time_in;
            primed <= 1'b1;
        end
    end

    // Commands outrank ticks; a start with INTERVAL == 0 is dropped in either state.
    always_comb begin
        state_nx  = state;
        remain_nx = remain;
        set_pend  = 1'b0;
        if (cmd_stop) begin
            if (state == RUN) begin
                state_nx  = IDLE;
                remain_nx = '0;
            end
        end else if (cmd_start) begin
            if (interval != '0) begin
                state_nx  = RUN;
                remain_nx = interval;
            end
        end else if ((state == RUN) && tick) begin
            if (remain > 16'd1) begin
                remain_nx = remain - 16'd1;
            end else begin
                set_pend = 1'b1;
                if (periodic && (interval != '0)) begin
                    remain_nx = interval;
                end else begin
                    state_nx  = IDLE;
                    remain_nx = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            remain <= '0;
        end else begin
            state  <= state_nx;
            remain <= remain_nx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            interval <= '0;
            periodic <= 1'b0;
            irq_en   <= 1'b0;
            pending  <= 1'b0;
        end else begin
            if (wr_interval) interval <= bus_wdata;
            if (wr_ctrl) begin
                periodic <= bus_wdata[1];
                irq_en   <= bus_wdata[2];
            end
            if (set_pend)
                pending <= 1'b1;
            else if (wr_status && bus_wdata[0])
                pending <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_rdata <= '0;
        end else if (bus_re) begin
            unique case (bus_addr)
                2'd0:    bus_rdata <= interval;
                2'd1:    bus_rdata <= {13'b0, irq_en, periodic, 1'b0};
                2'd2:    bus_rdata <= {14'b0, (state == RUN), pending};
                default: bus_rdata <= remain;
            endcase
        end
    end

endmodule

// File: tb/tb_timer_compare.sv
// Directed self-checking bench for timer_compare.
module tb_timer_compare;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] time_in;
    logic [1:0]  bus_addr;
    logic        bus_we, bus_re;
    logic [15:0] bus_wdata;
    logic [15:0] bus_rdata;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    localparam logic [1:0] A_INT = 2'd0, A_CTRL = 2'd1, A_STAT = 2'd2, A_REM = 2'd3;

    timer_compare dut (
        .clk      (clk),
        .rst      (rst),
        .time_in  (time_in),
        .bus_addr (bus_addr),
        .bus_we   (bus_we),
        .bus_re   (bus_re),
        .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        bus_addr = a; bus_wdata = d; bus_we = 1'b1;
        step();
        bus_we = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [15:0] exp, input string tag);
        bus_addr = a; bus_re = 1'b1;
        step();
        bus_re = 1'b0;
        check(tag, bus_rdata, exp);
    endtask

    task automatic inc();
        time_in = time_in + 16'd1;
        step();
    endtask

    initial begin
        rst = 1'b0; time_in = '0; bus_addr = '0; bus_we = 1'b0; bus_re = 1'b0; bus_wdata = '0;
        step(); step();
        check("reset_rdata", bus_rdata, 16'h0000);
        check("reset_irq", {15'b0, irq}, 16'h0000);
        rst = 1'b1;
        step();

        // One-shot
        wr(A_INT, 16'd3);
        wr(A_CTRL, 16'h0005);
        inc(); inc(); inc();
        check("oneshot_irq", {15'b0, irq}, 16'h0001);
        rd(A_STAT, 16'h0001, "oneshot_status");
        rd(A_REM, 16'h0000, "oneshot_remain");
        rd(A_CTRL, 16'h0004, "oneshot_ctrl");
        rd(A_INT, 16'h0003, "oneshot_interval");

        // Periodic
        wr(A_STAT, 16'h0001);
        check("clear_irq", {15'b0, irq}, 16'h0000);
        wr(A_INT, 16'd2);
        wr(A_CTRL, 16'h0007);
        rd(A_REM, 16'd2, "per_remain_start");
        for (int i = 0; i < 3; i++) begin
            inc();
            rd(A_REM, 16'd1, "per_remain_mid");
            inc();
            check("per_irq", {15'b0, irq}, 16'h0001);
            rd(A_STAT, 16'h0003, "per_status");
            wr(A_STAT, 16'h0001);
            check("per_irq_clr", {15'b0, irq}, 16'h0000);
            rd(A_REM, 16'd2, "per_remain_reload");
        end
        rd(A_CTRL, 16'h0006, "per_ctrl");
        wr(A_CTRL, 16'h0008);
        rd(A_STAT, 16'h0000, "per_stopped");

        // Collisions: tick with start, expiry with pending clear
        wr(A_INT, 16'd4);
        wr(A_CTRL, 16'h0001);
        inc();
        rd(A_REM, 16'd3, "col_remain_dec");
        time_in = time_in + 16'd1;
        wr(A_CTRL, 16'h0001);
        rd(A_REM, 16'd4, "col_tick_start");
        inc(); inc(); inc();
        rd(A_REM, 16'd1, "col_remain_one");
        time_in = time_in + 16'd1;
        wr(A_STAT, 16'h0001);
        rd(A_STAT, 16'h0001, "col_pend_wins");
        check("col_irq_masked", {15'b0, irq}, 16'h0000);
        wr(A_CTRL, 16'h0004);
        check("col_irq_unmask", {15'b0, irq}, 16'h0001);
        wr(A_CTRL, 16'h0000);
        check("col_irq_remask", {15'b0, irq}, 16'h0000);
        wr(A_STAT, 16'h0000);
        rd(A_STAT, 16'h0001, "col_write0_noeffect");
        wr(A_STAT, 16'h0001);
        rd(A_STAT, 16'h0000, "col_pend_cleared");

        // Edge commands
        wr(A_INT, 16'd0);
        wr(A_CTRL, 16'h0001);
        rd(A_STAT, 16'h0000, "edge_zero_start");
        wr(A_INT, 16'd5);
        wr(A_CTRL, 16'h0001);
        rd(A_STAT, 16'h0002, "edge_running");
        wr(A_CTRL, 16'h0009);
        rd(A_STAT, 16'h0000, "edge_startstop");
        rd(A_REM, 16'h0000, "edge_remain0");
        inc();
        rd(A_REM, 16'h0000, "edge_idle_tick");
        wr(A_REM, 16'h1234);
        rd(A_REM, 16'h0000, "edge_remain_ro");

        // Reset mid-run
        wr(A_INT, 16'd5);
        wr(A_CTRL, 16'h0005);
        rd(A_REM, 16'd5, "rst_remain_before");
        #2 rst = 1'b0;
        #1;
        check("rst_rdata_async", bus_rdata, 16'h0000);
        check("rst_irq_async", {15'b0, irq}, 16'h0000);
        inc(); inc();
        rst = 1'b1;
        step();
        rd(A_INT, 16'h0000, "rst_interval");
        rd(A_CTRL, 16'h0000, "rst_ctrl");
        rd(A_STAT, 16'h0000, "rst_status");
        rd(A_REM, 16'h0000, "rst_remain");
        inc(); inc(); inc(); inc(); inc();
        rd(A_REM, 16'h0000, "rst_no_count");
        check("rst_irq_after", {15'b0, irq}, 16'h0000);

        // Wrap and primed
        rst = 1'b0;
        time_in = 16'hFFFE;
        step();
        rst = 1'b1;
        step();
        wr(A_INT, 16'd2);
        wr(A_CTRL, 16'h0001);
        inc();
        rd(A_REM, 16'd1, "wrap_remain");
        inc();
        check("wrap_time", time_in, 16'h0000);
        rd(A_STAT, 16'h0001, "wrap_expiry");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/timer_compare.md
TIMER_COMPARE -- requirements
Module: timer_compare

Interface
REQ-001 clk  input  1  system clock; all state on rising edge.
REQ-002 rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003 time_in  input  16  free-running millisecond count from the timer stage; already synchronous to clk; advances by 1 (mod 2^16).
REQ-004 bus_addr  input  2  register select: 0 INTERVAL, 1 CTRL, 2 STATUS, 3 REMAIN.
REQ-005 bus_we  input  1  write strobe, one cycle per write.
REQ-006 bus_re  input  1  read strobe, one cycle per read.
REQ-007 bus_wdata  input  16  write data.
REQ-008 bus_rdata  output  16  read data, registered.
REQ-009 irq  output  1  level interrupt = pending AND irq_en.

Function
REQ-010 Tick detect: register prev holds the last time_in; tick = primed AND (time_in != prev); prev <= time_in every cycle.
REQ-011 primed clears on reset, sets on the first cycle after reset release; no tick is generated in that first cycle.
REQ-012 INTERVAL (addr 0, RW): 16-bit tick count; a write during RUN does not alter remain; it applies from the next start or periodic reload.
REQ-013 CTRL (addr 1) write: bit0 start (self-clearing), bit1 periodic, bit2 irq_en, bit3 stop (self-clearing); read returns {13'b0, irq_en, periodic, 1'b0}.
REQ-014 STATUS (addr 2): bit0 pending (write 1 clears, write 0 no effect), bit1 running (RO); other bits read 0.
REQ-015 REMAIN (addr 3, RO): current remain value; writes ignored.
REQ-016 FSM states: IDLE, RUN.
REQ-017 IDLE -> RUN on start with INTERVAL != 0; remain <= INTERVAL.
REQ-018 Start with INTERVAL == 0: ignored; state stays IDLE; remain is unchanged.
REQ-019 RUN, start: restart; remain <= INTERVAL; pending is unchanged.
REQ-020 RUN, stop: -> IDLE; remain <= 0; pending is unchanged.
REQ-021 Start and stop in the same write: stop wins.
REQ-022 RUN, tick with remain > 1: remain <= remain - 1.
REQ-023 RUN, tick with remain == 1 (expiry): pending <= 1; if periodic, remain <= INTERVAL and state stays RUN; otherwise remain <= 0 and state goes to IDLE.
REQ-024 A start/stop write in the same cycle as a tick takes priority; that tick is discarded.
REQ-025 Pending-clear write in the same cycle as an expiry: the set wins; pending stays 1.
REQ-026 Ticks in IDLE are ignored.
REQ-027 time_in wrap 0xFFFF -> 0x0000 is a normal tick.
REQ-028 Read: bus_re samples bus_addr; bus_rdata is valid the next cycle and holds until the next read.
REQ-029 If bus_re and bus_we occur in the same cycle, the read returns the pre-write value.
REQ-030 irq follows pending and irq_en combinationally from registers; clearing irq_en masks irq without clearing pending.

Reset
REQ-031 While rst = 0, reset values are: state IDLE, remain 0, INTERVAL 0, periodic 0, irq_en 0, pending 0, prev 0, primed 0, bus_rdata 0, irq 0.
REQ-032 Reset asserted mid-RUN aborts immediately to the reset values; there is no expiry and no irq.

Verification
REQ-033 One-shot: INTERVAL = 3, CTRL = 0x5, then 3 time_in increments -> pending = 1 and irq = 1 on the cycle after the 3rd change; state IDLE; REMAIN reads 0.
REQ-034 Periodic: INTERVAL = 2, CTRL = 0x7, 6 increments -> 3 expiries; clear pending after each; REMAIN cycles 2, 1, 2, ...; running stays 1.
REQ-035 Wrap and primed: release reset with time_in = 0xFFFE -> no tick in the first cycle; start INTERVAL = 2; time_in goes 0xFFFF then 0x0000 -> expiry.
REQ-036 Collisions: a tick coincident with a start write -> remain = INTERVAL (tick dropped); an expiry coincident with a STATUS write of 0x1 -> pending stays 1.
REQ-037 Edge commands: INTERVAL = 0 with start -> running stays 0; start|stop (0x9) during RUN -> IDLE, REMAIN = 0.
REQ-038 Reset: rst = 0 mid-RUN with remain = 5 -> all registers read 0 and irq = 0 after release; no further ticks are counted.
